// File: rtl/filter_accumulator_pkg.sv
// Shared constants and helpers for the multi-channel filter accumulator.
package filter_accumulator_pkg;

  localparam int DEF_DATA_W    = 16;
  localparam int DEF_ACC_W     = 20;
  localparam int DEF_NUM_CH    = 4;
  localparam int DEF_SAT_EN    = 1;
  localparam int DEF_CLR_ON_RD = 0;

  // Channel-select width; a single channel still gets a 1-bit select.
  function automatic int calc_ch_w(input int num_ch);
    return (num_ch <= 1) ? 1 : $clog2(num_ch);
  endfunction

  // Largest signed value representable in acc_w bits (low acc_w bits used).
  function automatic logic [63:0] sat_max(input int acc_w);
    return (64'd1 << (acc_w - 1)) - 64'd1;
  endfunction

  // Smallest signed value representable in acc_w bits (low acc_w bits used).
  function automatic logic [63:0] sat_min(input int acc_w);
    return ~sat_max(acc_w);
  endfunction

endpackage

// File: rtl/filter_accumulator_mc_if.sv
// Sample/read bus between the tap multiplier stage and the accumulator.
// Handshake: there is no back-pressure. A write is taken on every rising edge
// where enable=1, a read on every rising edge where rd_req=1; rd_valid pulses
// high for exactly one cycle, one edge after the rd_req it answers, and Q
// holds its last value whenever rd_valid=0.
interface filter_accumulator_mc_if
  import filter_accumulator_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ACC_W  = DEF_ACC_W,
  parameter int NUM_CH = DEF_NUM_CH
);
  localparam int CH_W = calc_ch_w(NUM_CH);

  logic              enable;
  logic              load;
  logic [CH_W-1:0]   ch;
  logic [DATA_W-1:0] D;
  logic              rd_req;
  logic [CH_W-1:0]   rd_ch;
  logic              rd_valid;
  logic [ACC_W-1:0]  Q;
  logic [NUM_CH-1:0] ovf;

  modport master (
    output enable, load, ch, D, rd_req, rd_ch,
    input  rd_valid, Q, ovf
  );

  modport slave (
    input  enable, load, ch, D, rd_req, rd_ch,
    output rd_valid, Q, ovf
  );
endinterface

// File: rtl/filter_acc_lane.sv
// One accumulator channel: load/accumulate, saturate or wrap, sticky overflow.
module filter_acc_lane
  import filter_accumulator_pkg::*;
#(
  parameter int ACC_W  = DEF_ACC_W,
  parameter int SAT_EN = DEF_SAT_EN
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we_i,
  input  logic             load_i,
  input  logic             clr_acc_i,
  input  logic             clr_ovf_i,
  input  logic [ACC_W-1:0] sample_i,
  output logic [ACC_W-1:0] acc_o,
  output logic             ovf_o
);
  localparam bit               SAT   = (SAT_EN != 0);
  localparam logic [ACC_W-1:0] MAX_V = ACC_W'(sat_max(ACC_W));
  localparam logic [ACC_W-1:0] MIN_V = ACC_W'(sat_min(ACC_W));

  logic [ACC_W-1:0] acc_q, acc_d;
  logic             ovf_q, ovf_d;
  logic [ACC_W-1:0] base;
  logic [ACC_W:0]   sum;
  logic             ovf_hit;

  // Next state: a same-cycle clear-on-read zeroes the operand the write sees,
  // and a fresh overflow outranks the read-side ovf clear.
  always_comb begin
    base    = clr_acc_i ? '0 : acc_q;
    sum     = {base[ACC_W-1], base} + {sample_i[ACC_W-1], sample_i};
    ovf_hit = we_i && !load_i && (sum[ACC_W] != sum[ACC_W-1]);
    acc_d   = base;
    if (we_i) begin
      if (load_i)             acc_d = sample_i;
      else if (ovf_hit && SAT) acc_d = sum[ACC_W] ? MIN_V : MAX_V;
      else                    acc_d = sum[ACC_W-1:0];
    end
    ovf_d = ovf_hit || (ovf_q && !clr_ovf_i);
  end

  // Accumulator and sticky flag registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      ovf_q <= ovf_d;
    end
  end

  assign acc_o = acc_q;
  assign ovf_o = ovf_q;
endmodule

// File: rtl/filter_accumulator_mc.sv
// NUM_CH independent signed accumulators fed from one sample bus, with a
// registered read port, optional clear-on-read and per-channel overflow flags.
module filter_accumulator_mc
  import filter_accumulator_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int ACC_W     = DEF_ACC_W,
  parameter int NUM_CH    = DEF_NUM_CH,
  parameter int SAT_EN    = DEF_SAT_EN,
  parameter int CLR_ON_RD = DEF_CLR_ON_RD
) (
  input logic               clk,
  input logic               rst,
  filter_accumulator_mc_if.slave bus
);
  localparam int CH_W   = calc_ch_w(NUM_CH);
  localparam bit CLR_EN = (CLR_ON_RD != 0);

  // The accumulator needs one guard bit above the sample to hold any load.
  if (ACC_W < DATA_W + 1) begin : g_bad_cfg
    $error("filter_accumulator_mc: ACC_W must be at least DATA_W+1");
  end

  logic [ACC_W-1:0]  sample_ext;
  logic [ACC_W-1:0]  acc_w [NUM_CH];
  logic [NUM_CH-1:0] ovf_w;
  logic [ACC_W-1:0]  rd_data;
  logic [ACC_W-1:0]  q_q, q_d;
  logic              rd_valid_q;

  assign sample_ext = {{(ACC_W-DATA_W){bus.D[DATA_W-1]}}, bus.D};

  // Channel decode: a select outside 0..NUM_CH-1 matches no lane, so such
  // writes are dropped and such reads fall through to zero in the mux.
  for (genvar i = 0; i < NUM_CH; i++) begin : g_lane
    logic wr_hit, rd_hit;
    assign wr_hit = bus.enable && (bus.ch == CH_W'(i));
    assign rd_hit = bus.rd_req && (bus.rd_ch == CH_W'(i));

    filter_acc_lane #(
      .ACC_W  (ACC_W),
      .SAT_EN (SAT_EN)
    ) u_lane (
      .clk       (clk),
      .rst       (rst),
      .we_i      (wr_hit),
      .load_i    (bus.load),
      .clr_acc_i (rd_hit && CLR_EN),
      .clr_ovf_i (rd_hit),
      .sample_i  (sample_ext),
      .acc_o     (acc_w[i]),
      .ovf_o     (ovf_w[i])
    );
  end

  // Read mux over pre-edge accumulator values; unknown channels read as zero.
  always_comb begin
    rd_data = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (bus.rd_ch == CH_W'(i)) rd_data = acc_w[i];
    end
    q_d = bus.rd_req ? rd_data : q_q;
  end

  // Read data register; Q holds between reads.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_q        <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      q_q        <= q_d;
      rd_valid_q <= bus.rd_req;
    end
  end

  assign bus.Q        = q_q;
  assign bus.rd_valid = rd_valid_q;
  assign bus.ovf      = ovf_w;
endmodule

// File: tb/tb_filter_accumulator_mc.sv
// Bench for filter_accumulator_mc: four configurations driven in lockstep,
// each checked every cycle against a behavioural model, plus literal pins.
module tb_filter_accumulator_mc;
  localparam int NCFG = 4;
  localparam longint MAXV = 524287;
  localparam longint MINV = -524288;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // ---------------- shared stimulus ----------------
  logic        t_en, t_ld, t_rr;
  logic [1:0]  t_ch, t_rch;
  logic [15:0] t_d;

  filter_accumulator_mc_if #(.DATA_W(16), .ACC_W(20), .NUM_CH(4)) bus_a ();
  filter_accumulator_mc_if #(.DATA_W(16), .ACC_W(20), .NUM_CH(4)) bus_b ();
  filter_accumulator_mc_if #(.DATA_W(16), .ACC_W(20), .NUM_CH(4)) bus_c ();
  filter_accumulator_mc_if #(.DATA_W(16), .ACC_W(20), .NUM_CH(3)) bus_d ();

  assign bus_a.enable = t_en; assign bus_a.load = t_ld; assign bus_a.ch = t_ch;
  assign bus_a.D = t_d; assign bus_a.rd_req = t_rr; assign bus_a.rd_ch = t_rch;
  assign bus_b.enable = t_en; assign bus_b.load = t_ld; assign bus_b.ch = t_ch;
  assign bus_b.D = t_d; assign bus_b.rd_req = t_rr; assign bus_b.rd_ch = t_rch;
  assign bus_c.enable = t_en; assign bus_c.load = t_ld; assign bus_c.ch = t_ch;
  assign bus_c.D = t_d; assign bus_c.rd_req = t_rr; assign bus_c.rd_ch = t_rch;
  assign bus_d.enable = t_en; assign bus_d.load = t_ld; assign bus_d.ch = t_ch;
  assign bus_d.D = t_d; assign bus_d.rd_req = t_rr; assign bus_d.rd_ch = t_rch;

  // cfg0: saturate; cfg1: wrap; cfg2: saturate + clear-on-read; cfg3: 3 channels
  filter_accumulator_mc #(.DATA_W(16), .ACC_W(20), .NUM_CH(4), .SAT_EN(1), .CLR_ON_RD(0))
    dut_a (.clk(clk), .rst(rst), .bus(bus_a));
  filter_accumulator_mc #(.DATA_W(16), .ACC_W(20), .NUM_CH(4), .SAT_EN(0), .CLR_ON_RD(0))
    dut_b (.clk(clk), .rst(rst), .bus(bus_b));
  filter_accumulator_mc #(.DATA_W(16), .ACC_W(20), .NUM_CH(4), .SAT_EN(1), .CLR_ON_RD(1))
    dut_c (.clk(clk), .rst(rst), .bus(bus_c));
  filter_accumulator_mc #(.DATA_W(16), .ACC_W(20), .NUM_CH(3), .SAT_EN(1), .CLR_ON_RD(0))
    dut_d (.clk(clk), .rst(rst), .bus(bus_d));

  logic [19:0] d_q   [NCFG];
  logic        d_rv  [NCFG];
  logic [3:0]  d_ovf [NCFG];
  assign d_q[0] = bus_a.Q; assign d_rv[0] = bus_a.rd_valid; assign d_ovf[0] = bus_a.ovf;
  assign d_q[1] = bus_b.Q; assign d_rv[1] = bus_b.rd_valid; assign d_ovf[1] = bus_b.ovf;
  assign d_q[2] = bus_c.Q; assign d_rv[2] = bus_c.rd_valid; assign d_ovf[2] = bus_c.ovf;
  assign d_q[3] = bus_d.Q; assign d_rv[3] = bus_d.rd_valid; assign d_ovf[3] = {1'b0, bus_d.ovf};

  // ---------------- behavioural model ----------------
  longint      m_acc [NCFG][4];
  logic [3:0]  m_ovf [NCFG];
  logic [19:0] m_q   [NCFG];
  logic        m_rv  [NCFG];

  function automatic bit cfg_sat(input int k); return k != 1; endfunction
  function automatic bit cfg_clr(input int k); return k == 2; endfunction
  function automatic int cfg_nch(input int k); return (k == 3) ? 3 : 4; endfunction

  function automatic longint wrap20(input longint s);
    longint u;
    u = s & 64'h00000000000FFFFF;
    if (u > MAXV) u = u - 1048576;
    return u;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NCFG; k++) begin
      for (int c = 0; c < 4; c++) m_acc[k][c] = 0;
      m_ovf[k] = '0;
      m_q[k]   = '0;
      m_rv[k]  = 1'b0;
    end
  endtask

  // One rising edge: read sees the old value, then its clear, then the write.
  task automatic model_step();
    longint s;
    for (int k = 0; k < NCFG; k++) begin
      m_rv[k] = t_rr;
      if (t_rr) begin
        if (int'(t_rch) < cfg_nch(k)) begin
          m_q[k] = m_acc[k][t_rch][19:0];
          m_ovf[k][t_rch] = 1'b0;
          if (cfg_clr(k)) m_acc[k][t_rch] = 0;
        end else begin
          m_q[k] = '0;
        end
      end
      if (t_en && int'(t_ch) < cfg_nch(k)) begin
        s = longint'($signed(t_d));
        if (!t_ld) s = m_acc[k][t_ch] + s;
        if (s > MAXV || s < MINV) begin
          m_ovf[k][t_ch] = 1'b1;
          if (cfg_sat(k)) s = (s > MAXV) ? MAXV : MINV;
          else            s = wrap20(s);
        end
        m_acc[k][t_ch] = s;
      end
    end
  endtask

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_err = 0;
  bit chk_on = 1'b0;

  task automatic check(input string name, input int k, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cfg%0d @%0t: got %h expected %h", name, k, $time, act, exp);
    end
  endtask

  // Literal pin: checks both the DUT and the model against a hand value.
  task automatic lit_q(input string name, input int k, input logic [19:0] exp);
    check(name, k, 32'(d_q[k]), 32'(exp));
    check({name, "_model"}, k, 32'(m_q[k]), 32'(exp));
  endtask

  task automatic lit_ovf(input string name, input int k, input logic [3:0] exp);
    check(name, k, 32'(d_ovf[k]), 32'(exp));
    check({name, "_model"}, k, 32'(m_ovf[k]), 32'(exp));
  endtask

  // Every falling edge: all registered outputs of all configurations.
  initial begin
    forever begin
      @(negedge clk);
      if (chk_on) begin
        for (int k = 0; k < NCFG; k++) begin
          check("q", k, 32'(d_q[k]), 32'(m_q[k]));
          check("rd_valid", k, 32'(d_rv[k]), 32'(m_rv[k]));
          check("ovf", k, 32'(d_ovf[k]), 32'(m_ovf[k]));
        end
      end
    end
  end

  // ---------------- driver ----------------
  task automatic drive(input int en, input int ld, input int ch, input int d,
                       input int rr, input int rch);
    t_en  = (en != 0);
    t_ld  = (ld != 0);
    t_ch  = 2'(ch);
    t_d   = 16'(d);
    t_rr  = (rr != 0);
    t_rch = 2'(rch);
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  initial begin
    t_en = 0; t_ld = 0; t_ch = 0; t_d = 0; t_rr = 0; t_rch = 0;
    rst = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
    chk_on = 1'b1;
    for (int k = 0; k < NCFG; k++) begin
      check("reset_q", k, 32'(d_q[k]), 32'h0);
      check("reset_rv", k, 32'(d_rv[k]), 32'h0);
      check("reset_ovf", k, 32'(d_ovf[k]), 32'h0);
    end
    rst = 1'b0;

    // Basic load/accumulate: 10 - 1 + 820 - 1 = 828
    drive(1, 1, 0, 16'h000A, 0, 0);
    drive(1, 0, 0, 16'hFFFF, 0, 0);
    drive(1, 0, 0, 16'h0334, 0, 0);
    drive(1, 0, 0, 16'hFFFF, 0, 0);
    drive(0, 0, 0, 0, 1, 0);
    for (int k = 0; k < NCFG; k++) lit_q("basic_q", k, 20'h0033C);
    lit_ovf("basic_ovf", 0, 4'h0);

    // Positive overflow: 21 x 0x7FFF
    drive(1, 1, 0, 16'h7FFF, 0, 0);
    repeat (20) drive(1, 0, 0, 16'h7FFF, 0, 0);
    lit_ovf("pos_ovf_pre", 0, 4'h1);
    lit_ovf("pos_ovf_pre", 1, 4'h1);
    drive(0, 0, 0, 0, 1, 0);
    lit_q("pos_sat_q", 0, 20'h7FFFF);
    lit_q("pos_wrap_q", 1, 20'hA7FEB);
    lit_ovf("pos_ovf_post", 0, 4'h0);

    // Negative overflow: 21 x 0x8000
    drive(1, 1, 0, 16'h8000, 0, 0);
    repeat (20) drive(1, 0, 0, 16'h8000, 0, 0);
    drive(0, 0, 0, 0, 1, 0);
    lit_q("neg_sat_q", 0, 20'h80000);
    lit_q("neg_wrap_q", 1, 20'h58000);

    // Interleaved channels, then reads: ch i holds 11*(i+1)
    for (int i = 0; i < 4; i++) drive(1, 1, i, i + 1, 0, 0);
    for (int i = 0; i < 4; i++) drive(1, 0, i, 10 * (i + 1), 0, 0);
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 0, 0, 1, i);
      lit_q("chan_q", 0, 20'(11 * (i + 1)));
    end
    check("oob_rd_q", 3, 32'(d_q[3]), 32'h0);
    check("oob_rd_valid", 3, 32'(d_rv[3]), 32'h1);

    // Clear-on-read with a same-cycle accumulate to the read channel
    drive(1, 1, 2, 5, 0, 0);
    drive(1, 0, 2, 3, 1, 2);
    lit_q("cor_first_q", 2, 20'h00005);
    lit_q("nocor_first_q", 0, 20'h00005);
    drive(0, 0, 0, 0, 1, 2);
    lit_q("cor_second_q", 2, 20'h00003);
    lit_q("nocor_second_q", 0, 20'h00008);

    // Randomised traffic, biased positive then negative to provoke overflow
    for (int n = 0; n < 1500; n++) begin
      int d;
      if ($urandom_range(0, 4) == 0) d = int'($urandom_range(0, 65535));
      else if (n < 750)             d = int'($urandom_range(16'h4000, 16'h7FFF));
      else                          d = int'($urandom_range(16'h8000, 16'hBFFF));
      drive(($urandom_range(0, 4) != 0) ? 1 : 0, ($urandom_range(0, 31) == 0) ? 1 : 0,
            int'($urandom_range(0, 3)), d, ($urandom_range(0, 2) == 0) ? 1 : 0,
            int'($urandom_range(0, 3)));
    end

    // Asynchronous reset in the middle of an accumulate with a read pending
    drive(1, 1, 1, 16'h1234, 0, 0);
    drive(0, 0, 0, 0, 1, 1);
    lit_q("pre_rst_q", 0, 20'h01234);
    t_en = 1; t_ld = 0; t_ch = 2'd1; t_d = 16'h0100; t_rr = 1; t_rch = 2'd1;
    @(posedge clk);
    model_step();
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    for (int k = 0; k < NCFG; k++) begin
      check("async_rst_q", k, 32'(d_q[k]), 32'h0);
      check("async_rst_rv", k, 32'(d_rv[k]), 32'h0);
      check("async_rst_ovf", k, 32'(d_ovf[k]), 32'h0);
    end
    @(negedge clk);
    t_en = 0; t_ld = 0; t_ch = 0; t_d = 0; t_rr = 0; t_rch = 0;
    @(negedge clk);
    rst = 1'b0;

    // Idle writes (enable low) must leave every channel untouched
    drive(1, 1, 1, 16'h0007, 0, 0);
    repeat (10) drive(0, int'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
                      int'($urandom_range(0, 65535)), 0, 0);
    drive(0, 0, 0, 0, 1, 1);
    for (int k = 0; k < NCFG; k++) lit_q("idle_q", k, 20'h00007);
    drive(0, 0, 0, 0, 1, 0);
    for (int k = 0; k < NCFG; k++) lit_q("idle_ch0_q", k, 20'h00000);
    drive(0, 0, 0, 0, 0, 0);

    chk_on = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/filter_accumulator_mc.md
# filter_accumulator_mc

Multi-channel, parametrised successor to the single-channel filter accumulator. Holds NUM_CH independent signed accumulators, each loaded or accumulated from a shared sample bus. Adds optional saturation, per-channel sticky overflow flags and a registered read port with clear-on-read. Sits between the FIR tap multiplier stage and the filter output formatter.

## Interface
- DATA_W, 16: sample width, signed two's complement.
- ACC_W, 20: accumulator width. Must be ≥ DATA_W+1; elaboration fails otherwise.
- NUM_CH, 4: channel count, ≥ 1. CH_W = max(1, clog2(NUM_CH)).
- SAT_EN, 1: 1 = saturate at signed ACC_W limits; 0 = two's-complement wrap.
- CLR_ON_RD, 0: 1 = a granted read zeroes the read channel.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- enable  in  1  write strobe. A write happens only when enable=1.
- load  in  1  qualifies a write: 1 = load, 0 = accumulate.
- ch  in  CH_W  write channel select.
- D  in  DATA_W  signed sample.
- rd_req  in  1  read request.
- rd_ch  in  CH_W  read channel select.
- rd_valid  out  1  read data valid, one cycle after rd_req.
- Q  out  ACC_W  read data.
- ovf  out  NUM_CH  sticky overflow flag per channel.

## Operation
- Write, enable=1 and load=1: acc[ch] ← sign_extend(D).
- Write, enable=1 and load=0: acc[ch] ← acc[ch] + sign_extend(D). The sum is computed at ACC_W+1 bits.
  - Overflow means the ACC_W+1-bit sum lies outside [−2^(ACC_W−1), 2^(ACC_W−1)−1].
  - On overflow, ovf[ch] is set. With SAT_EN=1 the result is clamped to the violated limit; with SAT_EN=0 the result wraps.
- Write with enable=0: no state change. load is ignored.
- A write to a channel ≥ NUM_CH is dropped with no state change. A read from a channel ≥ NUM_CH returns Q=0 with rd_valid=1.
- Read, rd_req=1:
  - Q ← acc[rd_ch] as it stood before this edge's write.
  - rd_valid goes high for one cycle.
  - ovf[rd_ch] is cleared.
  - If CLR_ON_RD=1, acc[rd_ch] ← 0.
- Simultaneous read and write, same channel:
  - Q returns the pre-write value.
  - With CLR_ON_RD=1, the write is applied to zero: load gives sign_extend(D), accumulate gives 0+sign_extend(D).
  - If this write overflows, ovf[rd_ch] is set. A new overflow wins over the read-clear.
- Simultaneous read and write, different channels: the two operations are independent.
- No back-pressure; one read and one write can be accepted every cycle.

## Timing
- Reset values: all acc = 0, Q = 0, rd_valid = 0, ovf = 0. Reset applies immediately and asynchronously, mid-operation included; the first write is accepted on the first edge after rst deasserts.
- A write becomes visible to a read issued on the following cycle, i.e. a read-after-write is seen one edge later.
- Read latency is 1 cycle: rd_req at edge N gives Q and rd_valid at edge N+1.
- Q holds its last value while rd_valid=0.
- ovf is registered: it is set at the same edge as the overflowing write and visible one cycle later.

## Structure
- Shared package filter_accumulator_pkg holds:
  - the function that computes CH_W;
  - the saturation-limit functions sat_max(ACC_W) and sat_min(ACC_W);
  - default parameter constants.
- Sub-module filter_acc_lane, one instance per channel:
  - inputs: write-enable, load, clear and the sign-extended sample;
  - holds that channel's accumulator register and ovf flag;
  - performs the add, saturate/wrap and overflow detection.
- The top level does channel decode, the read mux, the Q/rd_valid registers and the clear-on-read gating.

## Test plan
- Reset, then ch=0, load D=0x000A, then accumulate 0xFFFF, 0x0334, 0xFFFF, then read ch0 -> Q=0x0033C, ovf=0.
- SAT_EN=1, ACC_W=20: load 0x7FFF, then accumulate 0x7FFF for 20 cycles, then read -> Q=0x7FFFF, ovf[0]=1 before the read and 0 after it. Repeat with 0x8000 -> Q=0x80000.
- SAT_EN=0, same stimulus -> Q is the wrapped value (0x7FFF × 21 mod 2^20 = 0xA7FEB), ovf[0]=1.
- NUM_CH=4, interleaved loads ch0..3 = 1, 2, 3, 4 followed by accumulates -> each channel's read matches its own sum, with no cross-talk.
- CLR_ON_RD=1, acc[2]=5: rd_req with rd_ch=2 and a same-cycle accumulate of D=3 to ch2 -> Q=5, then a read the next cycle -> Q=3.
- Assert rst mid-accumulation with rd_req high -> all outputs go to 0 immediately; enable=0 for 10 cycles -> no change in any channel.
